relu_stream_ctrl: RTL and testbench
===================================

# relu_stream_ctrl

Sequencer for the activation stage behind the systolic-array accumulator drain. It accepts a tile job (element count plus activation mode), streams signed elements through a ReLU/clamp datapath with valid/ready handshakes on both sides, and registers the results. It counts accepted elements, counts zeroed and clipped elements for sparsity statistics, and pulses `done_o` once the last result has left the block.

## Interface
- `BITWIDTH`, 8: signed element width.
- `LEN_W`, 16: width of the job length and statistics counters.
- `MAX_VAL`, 6: positive clamp ceiling for mode RELU_CLAMP. Must satisfy 0 < `MAX_VAL` ≤ 2^(BITWIDTH-1)-1.

Ports:
- `clk_i` in 1: single clock. All logic is on the rising edge.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `start_i` in 1: job start. Sampled only in IDLE.
- `mode_i` in 2: activation mode, latched on start.
- `len_i` in LEN_W: number of elements in the job, latched on start.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse at job completion.
- `in_valid_i` in 1: upstream element valid.
- `in_ready_o` out 1: block accepts an element.
- `data_i` in BITWIDTH: signed input element.
- `out_valid_o` out 1: output register holds a result.
- `out_ready_i` in 1: downstream accepts the result.
- `result_o` out BITWIDTH: signed activated element.
- `zero_cnt_o` out LEN_W: elements forced to 0 in the current or last job.
- `clip_cnt_o` out LEN_W: elements clamped to `MAX_VAL` in the current or last job.

## Operation
- Modes:
  - 0 BYPASS: result = x.
  - 1 RELU: result = (x < 0) ? 0 : x.
  - 2 RELU_CLAMP: RELU, then result = MAX_VAL if x > MAX_VAL.
  - 3 is reserved and behaves as RELU.
- All comparisons are signed. No widening is needed; the result always fits in BITWIDTH.
- `zero_cnt_o` increments on each accepted element with x < 0 when mode ≠ BYPASS. An element with x = 0 does not count.
- `clip_cnt_o` increments on each accepted element with x > MAX_VAL when in RELU_CLAMP.
- Both statistics counters clear on job start and saturate at all-ones.
- States:
  - IDLE: `start_i` latches `mode_i` and `len_i`, clears `acc_cnt` and the statistics, then goes to RUN. If `len_i` = 0, go to DONE instead.
  - RUN: accept elements. Accept means `in_valid_i` && `in_ready_o`, and increments `acc_cnt`. The accept that brings `acc_cnt` to len moves the state to DRAIN.
  - DRAIN: hold `in_ready_o` = 0. When the output register is empty, or is emptying this cycle, go to DONE.
  - DONE: `done_o` = 1 for exactly one cycle, then go to IDLE.
- `in_ready_o` = (state == RUN) && (!`out_valid_o` || `out_ready_i`). There are no bubbles at full throughput.
- Output register:
  - Loads on accept and sets `out_valid_o`.
  - Clears `out_valid_o` on `out_ready_i` when there is no simultaneous accept.
  - On simultaneous accept and drain it stays valid with the new data.
- While `out_valid_o` && !`out_ready_i`, `result_o` must hold stable.
- `start_i` outside IDLE is ignored; it is not queued.
- `len_i` and `mode_i` changes after start have no effect on the running job.

## Timing
- Reset (`rst_n_i` = 0 at a clock edge), including mid-job:
  - State goes to IDLE.
  - `busy_o`, `done_o`, `in_ready_o`, `out_valid_o` = 0.
  - `result_o`, `zero_cnt_o`, `clip_cnt_o` = 0.
  - Any in-flight element is discarded and no `done_o` is issued.
- Latency: an element accepted at edge N appears on `result_o` with `out_valid_o` = 1 after edge N.
- Start to first possible accept: `start_i` at edge N gives RUN after N, so the first accept can happen at edge N+1.
- `done_o` timing:
  - It asserts in the cycle after the last result handshakes.
  - When the last result drains in the cycle it is accepted, the path is RUN → DRAIN → DONE, so `done_o` asserts 2 cycles after the last accept edge.
  - For `len_i` = 0, `done_o` asserts the cycle after the start edge.
- `busy_o` is asserted from the cycle after start until the cycle after the `done_o` pulse, and is low together with IDLE.
- Statistics are valid and stable from the `done_o` cycle until the next start.

## Structure
- Shared package `relu_pkg`:
  - Mode encodings: MODE_BYPASS, MODE_RELU, MODE_RELU_CLAMP, MODE_RSVD.
  - State encoding: ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE.
- One combinational sub-module, `relu_act_core` (parameters BITWIDTH, MAX_VAL):
  - Inputs: mode and x.
  - Outputs: result, is_zeroed, is_clipped.
- The FSM, counters and output register live in `relu_stream_ctrl`.

## Test plan
- BITWIDTH=8, mode RELU, len 4, input stream -5, 0, 3, 127 with `out_ready_i` = 1 → outputs 0, 0, 3, 127 on consecutive cycles; `zero_cnt_o` = 1, `clip_cnt_o` = 0; `done_o` 2 cycles after the 4th accept.
- Mode RELU_CLAMP (MAX_VAL=6), len 3, input stream 7, -128, 6 → outputs 6, 0, 6; `zero_cnt_o` = 1, `clip_cnt_o` = 1.
- Backpressure: mode BYPASS, len 3, `out_ready_i` low for 3 cycles after the first result → `result_o` holds its value, `in_ready_o` = 0 while the register is full, no element lost or duplicated, `done_o` only after the 3rd output handshake.
- `len_i` = 0 start → `done_o` pulse next cycle, `in_ready_o` never asserts; `start_i` pulsed during RUN of a len-5 job → ignored, exactly 5 accepts.
- Reset asserted in DRAIN with `out_valid_o` = 1 → next cycle all outputs 0, IDLE; a following len-2 job completes normally with counters starting from 0.

Source files
------------

// File: rtl/relu_pkg.sv
// Shared encodings for the activation-stage sequencer.
package relu_pkg;

    // Activation modes as presented on mode_i.
    typedef enum logic [1:0] {
        MODE_BYPASS     = 2'd0,
        MODE_RELU       = 2'd1,
        MODE_RELU_CLAMP = 2'd2,
        MODE_RSVD       = 2'd3
    } mode_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/relu_act_core.sv
// Combinational ReLU / clamp datapath for one signed element.
// The reserved mode is handled like plain ReLU.
module relu_act_core
    import relu_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int MAX_VAL  = 6
) (
    input  mode_e                      mode,
    input  logic signed [BITWIDTH-1:0] x,
    output logic signed [BITWIDTH-1:0] result,
    output logic                       is_zeroed,
    output logic                       is_clipped
);

    localparam logic signed [BITWIDTH-1:0] MAX_S  = BITWIDTH'(MAX_VAL);
    localparam logic signed [BITWIDTH-1:0] ZERO_S = {BITWIDTH{1'b0}};

    logic is_neg_s;
    logic is_big_s;

    assign is_neg_s = (x < ZERO_S);
    assign is_big_s = (x > MAX_S);

    // Select the activated value and flag zeroing / clipping events.
    always_comb begin
        result     = x;
        is_zeroed  = 1'b0;
        is_clipped = 1'b0;
        case (mode)
            MODE_BYPASS: begin
                result = x;
            end
            MODE_RELU_CLAMP: begin
                if (is_neg_s) begin
                    result    = ZERO_S;
                    is_zeroed = 1'b1;
                end else if (is_big_s) begin
                    result     = MAX_S;
                    is_clipped = 1'b1;
                end else begin
                    result = x;
                end
            end
            default: begin
                if (is_neg_s) begin
                    result    = ZERO_S;
                    is_zeroed = 1'b1;
                end else begin
                    result = x;
                end
            end
        endcase
    end

endmodule

// File: rtl/relu_stream_ctrl.sv
// Activation-stage sequencer: accepts a tile job, streams elements through
// relu_act_core with valid/ready on both sides, registers each result and
// keeps zero/clip statistics for the job.
module relu_stream_ctrl
    import relu_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int LEN_W    = 16,
    parameter int MAX_VAL  = 6
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [1:0]          mode_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic                busy_o,
    output logic                done_o,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [BITWIDTH-1:0] data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [BITWIDTH-1:0] result_o,
    output logic [LEN_W-1:0]    zero_cnt_o,
    output logic [LEN_W-1:0]    clip_cnt_o
);

    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

    // Saturating increment for the statistics counters.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + LEN_ONE;
        end
    endfunction

    state_e              state_r;
    state_e              state_nxt_s;
    mode_e               mode_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    acc_cnt_r;
    logic [LEN_W-1:0]    acc_inc_s;
    logic                out_valid_r;
    logic [BITWIDTH-1:0] result_r;
    logic [LEN_W-1:0]    zero_cnt_r;
    logic [LEN_W-1:0]    clip_cnt_r;
    logic                in_ready_s;
    logic                accept_s;
    logic                start_ok_s;
    logic [BITWIDTH-1:0] core_result_s;
    logic                core_zero_s;
    logic                core_clip_s;

    assign start_ok_s = (state_r == ST_IDLE) && start_i;
    assign in_ready_s = (state_r == ST_RUN) && (!out_valid_r || out_ready_i);
    assign accept_s   = in_valid_i && in_ready_s;
    assign acc_inc_s  = acc_cnt_r + LEN_ONE;

    relu_act_core #(
        .BITWIDTH (BITWIDTH),
        .MAX_VAL  (MAX_VAL)
    ) u_core (
        .mode       (mode_r),
        .x          (data_i),
        .result     (core_result_s),
        .is_zeroed  (core_zero_s),
        .is_clipped (core_clip_s)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: drain waits for the output register to empty.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt_s = (len_i == LEN_ZERO) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && (acc_inc_s == len_r)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_r || out_ready_i) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Job parameters and accepted-element counter.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mode_r    <= MODE_BYPASS;
            len_r     <= LEN_ZERO;
            acc_cnt_r <= LEN_ZERO;
        end else if (start_ok_s) begin
            mode_r    <= mode_e'(mode_i);
            len_r     <= len_i;
            acc_cnt_r <= LEN_ZERO;
        end else if (accept_s) begin
            acc_cnt_r <= acc_inc_s;
        end else begin
            acc_cnt_r <= acc_cnt_r;
        end
    end

    // Sparsity statistics, cleared on start and saturating.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            zero_cnt_r <= LEN_ZERO;
            clip_cnt_r <= LEN_ZERO;
        end else if (start_ok_s) begin
            zero_cnt_r <= LEN_ZERO;
            clip_cnt_r <= LEN_ZERO;
        end else if (accept_s) begin
            zero_cnt_r <= core_zero_s ? sat_inc(zero_cnt_r) : zero_cnt_r;
            clip_cnt_r <= core_clip_s ? sat_inc(clip_cnt_r) : clip_cnt_r;
        end else begin
            zero_cnt_r <= zero_cnt_r;
            clip_cnt_r <= clip_cnt_r;
        end
    end

    // Output register: a new accept wins over a drain, so throughput has no bubbles.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_r <= 1'b0;
            result_r    <= {BITWIDTH{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            result_r    <= core_result_s;
        end else if (out_ready_i) begin
            out_valid_r <= 1'b0;
            result_r    <= result_r;
        end else begin
            out_valid_r <= out_valid_r;
            result_r    <= result_r;
        end
    end

    assign busy_o      = (state_r != ST_IDLE);
    assign done_o      = (state_r == ST_DONE);
    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_valid_r;
    assign result_o    = result_r;
    assign zero_cnt_o  = zero_cnt_r;
    assign clip_cnt_o  = clip_cnt_r;

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Self-checking bench for relu_stream_ctrl: a vector table of single-element
// jobs, hand-written corner sequences and randomized jobs against a model.
module tb_relu_stream_ctrl;

    localparam int BW   = 8;
    localparam int LW   = 16;
    localparam int MAXV = 6;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          start_i;
    logic [1:0]    mode_i;
    logic [LW-1:0] len_i;
    logic          busy_o;
    logic          done_o;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [BW-1:0] data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [BW-1:0] result_o;
    logic [LW-1:0] zero_cnt_o;
    logic [LW-1:0] clip_cnt_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];
    int         exp_zero;
    int         exp_clip;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] x;
        logic [7:0] res;
        int         z;
        int         c;
    } vec_t;
    vec_t tbl[12];

    relu_stream_ctrl #(.BITWIDTH(BW), .LEN_W(LW), .MAX_VAL(MAXV)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .zero_cnt_o  (zero_cnt_o),
        .clip_cnt_o  (clip_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference activation from the mode rules, in plain integer arithmetic.
    function automatic int act_int(input logic [1:0] m, input int x);
        if (m == 2'd0) return x;
        if (x < 0) return 0;
        if (m == 2'd2 && x > MAXV) return MAXV;
        return x;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   {31'd0, busy_o},      32'd0);
        chk({tag, "_done"},   {31'd0, done_o},      32'd0);
        chk({tag, "_inrdy"},  {31'd0, in_ready_o},  32'd0);
        chk({tag, "_ovalid"}, {31'd0, out_valid_o}, 32'd0);
        chk({tag, "_result"}, {24'd0, result_o},    32'd0);
        chk({tag, "_zcnt"},   {16'd0, zero_cnt_o},  32'd0);
        chk({tag, "_ccnt"},   {16'd0, clip_cnt_o},  32'd0);
    endtask

    // Runs one job using in_q/exp_q/exp_zero/exp_clip.
    // vmode: 0 = always valid, 1 = random valid (and junk valid after the job's elements)
    // rmode: 0 = always ready, 1 = random ready, 2 = ready low 3 cycles after first result
    task automatic run_job(input logic [1:0] m, input int n, input int vmode, input int rmode,
                           input bit poke);
        int acc = 0, hs = 0, outst = 0, it = 0;
        int last_acc = -1, last_hs = -1, done_it = -1, first_out = -1;
        bit hold = 1'b0;
        logic [7:0] hold_val = 8'd0;
        @(negedge clk);
        start_i = 1'b1; mode_i = m; len_i = LW'(n);
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        while (done_it < 0 && it < 400) begin
            @(negedge clk);
            start_i = poke && (it == 2);
            mode_i  = 2'($urandom);
            len_i   = LW'($urandom_range(1, 20));
            if (acc < n) begin
                in_valid_i = (vmode == 0) ? 1'b1 : (($urandom % 3) != 0);
                data_i     = in_q[acc];
            end else begin
                in_valid_i = (vmode == 0) ? 1'b0 : 1'($urandom);
                data_i     = 8'($urandom);
            end
            if (outst > 0 && first_out < 0) first_out = it;
            case (rmode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (($urandom % 4) != 0);
                default: out_ready_i = !(first_out >= 0 && it < first_out + 3);
            endcase
            #1;
            chk("out_valid", {31'd0, out_valid_o}, {31'd0, outst != 0});
            chk("in_ready", {31'd0, in_ready_o}, {31'd0, (acc < n) && (outst == 0 || out_ready_i)});
            chk("busy", {31'd0, busy_o}, 32'd1);
            if (hold) chk("hold_result", {24'd0, result_o}, {24'd0, hold_val});
            if (done_o) begin
                done_it = it;
                chk("done_all_out", hs, n);
                if (last_hs >= 0) chk("done_after_hs", it - last_hs, 1);
                chk("zero_cnt", {16'd0, zero_cnt_o}, exp_zero);
                chk("clip_cnt", {16'd0, clip_cnt_o}, exp_clip);
            end
            if (out_valid_o && out_ready_i && hs < n) begin
                chk("result", {24'd0, result_o}, {24'd0, exp_q[hs]});
                hs++; last_hs = it; outst--;
            end
            hold     = out_valid_o && !out_ready_i;
            hold_val = result_o;
            if (in_valid_i && in_ready_o) begin
                acc++; last_acc = it; outst++;
            end
            it++;
        end
        if (done_it < 0) chk("timeout_done", 32'd0, 32'd1);
        chk("accepts", acc, n);
        if (n == 0) chk("len0_done_next", done_it, 0);
        if (n > 0 && rmode == 0 && vmode == 0) chk("done_latency", done_it - last_acc, 2);
        @(negedge clk);
        start_i = 1'b0; in_valid_i = 1'b0;
        #1;
        chk("done_pulse_one", {31'd0, done_o}, 32'd0);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
        chk("zero_stable", {16'd0, zero_cnt_o}, exp_zero);
        chk("clip_stable", {16'd0, clip_cnt_o}, exp_clip);
    endtask

    task automatic load_model_job(input logic [1:0] m, input int n);
        in_q.delete(); exp_q.delete();
        exp_zero = 0; exp_clip = 0;
        for (int i = 0; i < n; i++) begin
            int x;
            x = int'($urandom_range(0, 255)) - 128;
            in_q.push_back(8'(x));
            exp_q.push_back(8'(act_int(m, x)));
            if (m != 2'd0 && x < 0) exp_zero++;
            if (m == 2'd2 && x > MAXV) exp_clip++;
        end
    endtask

    initial begin
        tbl[0]  = '{2'd1, 8'hFB, 8'h00, 1, 0};
        tbl[1]  = '{2'd1, 8'h00, 8'h00, 0, 0};
        tbl[2]  = '{2'd1, 8'h7F, 8'h7F, 0, 0};
        tbl[3]  = '{2'd0, 8'h80, 8'h80, 0, 0};
        tbl[4]  = '{2'd0, 8'h05, 8'h05, 0, 0};
        tbl[5]  = '{2'd2, 8'h07, 8'h06, 0, 1};
        tbl[6]  = '{2'd2, 8'h06, 8'h06, 0, 0};
        tbl[7]  = '{2'd2, 8'h80, 8'h00, 1, 0};
        tbl[8]  = '{2'd2, 8'h7F, 8'h06, 0, 1};
        tbl[9]  = '{2'd3, 8'hFF, 8'h00, 1, 0};
        tbl[10] = '{2'd3, 8'h64, 8'h64, 0, 0};
        tbl[11] = '{2'd2, 8'h00, 8'h00, 0, 0};

        rst_n_i = 1'b0; start_i = 1'b0; mode_i = 2'd0; len_i = '0;
        in_valid_i = 1'b0; data_i = 8'd0; out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst_n_i = 1'b1;

        // single-element jobs from the vector table
        for (int i = 0; i < 12; i++) begin
            in_q  = '{tbl[i].x};
            exp_q = '{tbl[i].res};
            exp_zero = tbl[i].z; exp_clip = tbl[i].c;
            run_job(tbl[i].mode, 1, 0, 0, 1'b0);
        end

        // RELU stream at full throughput
        in_q  = '{8'hFB, 8'h00, 8'h03, 8'h7F};
        exp_q = '{8'h00, 8'h00, 8'h03, 8'h7F};
        exp_zero = 1; exp_clip = 0;
        run_job(2'd1, 4, 0, 0, 1'b0);

        // len 0: done next cycle, never ready, statistics cleared
        in_q.delete(); exp_q.delete();
        exp_zero = 0; exp_clip = 0;
        run_job(2'd1, 0, 1, 0, 1'b0);

        // clamp stream
        in_q  = '{8'h07, 8'h80, 8'h06};
        exp_q = '{8'h06, 8'h00, 8'h06};
        exp_zero = 1; exp_clip = 1;
        run_job(2'd2, 3, 0, 0, 1'b0);

        // backpressure after the first result
        in_q  = '{8'h11, 8'hA2, 8'h33};
        exp_q = '{8'h11, 8'hA2, 8'h33};
        exp_zero = 0; exp_clip = 0;
        run_job(2'd0, 3, 0, 2, 1'b0);

        // start pulsed while running is ignored
        load_model_job(2'd1, 5);
        run_job(2'd1, 5, 1, 1, 1'b1);

        // reset while draining a full output register
        @(negedge clk);
        start_i = 1'b1; mode_i = 2'd0; len_i = 16'd1; out_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0; in_valid_i = 1'b1; data_i = 8'h55;
        @(negedge clk);
        in_valid_i = 1'b0;
        #1;
        chk("drain_ovalid", {31'd0, out_valid_o}, 32'd1);
        chk("drain_result", {24'd0, result_o}, 32'h55);
        chk("drain_inrdy", {31'd0, in_ready_o}, 32'd0);
        @(negedge clk);
        rst_n_i = 1'b0; out_ready_i = 1'b1;
        @(negedge clk);
        #1;
        chk_all_zero("midreset");
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("no_done_after_reset", {31'd0, done_o}, 32'd0);
            chk("idle_after_reset", {31'd0, busy_o}, 32'd0);
        end
        in_q  = '{8'hFD, 8'h09};
        exp_q = '{8'h00, 8'h09};
        exp_zero = 1; exp_clip = 0;
        run_job(2'd1, 2, 0, 0, 1'b0);

        // randomized jobs against the model
        for (int j = 0; j < 20; j++) begin
            logic [1:0] m;
            int n;
            m = 2'($urandom);
            n = $urandom_range(1, 12);
            load_model_job(m, n);
            run_job(m, n, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
